// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready request port and a registered
// result port. Most opcodes finish in one cycle; unsigned multiply runs an
// iterative shift-add over WIDTH cycles. The finished result is held until the
// consumer takes it.
//
// Handshake: a request moves in on a rising edge where in_valid && in_ready,
// and a result moves out on a rising edge where out_valid && out_ready. A valid
// request or result stays put until the matching ready is seen. in_ready is
// high only in IDLE and out_valid only in HOLD, so at most one operation is in
// flight.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake
//   inst[3:0]            opcode
//   operand_1/operand_2  operands A and B (B is the shift amount for shifts)
//   out_valid/out_ready  result handshake
//   sol[WIDTH-1:0]       registered result
//   flags[3:0]           registered {err, ovf, carry, zero}
//   dbg_state[1:0]       FSM state: 0 IDLE, 1 MUL, 2 HOLD
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       inst,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sol,
    output logic [3:0]       flags,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     sol_q, sol_d;
    logic [3:0]           flags_q, flags_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Single-cycle datapath, evaluated on the live inputs while IDLE.
    logic [WIDTH:0]       sum, diff;
    logic                 shamt_big;
    logic [WIDTH-1:0]     alu_sol;
    logic                 alu_err, alu_ovf, alu_carry, alu_zero;

    always_comb begin
        alu_sol   = '0;
        alu_err   = 1'b0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        sum       = {1'b0, operand_1} + {1'b0, operand_2};
        // Top bit of the widened difference is the borrow (A < B unsigned).
        diff      = {1'b0, operand_1} - {1'b0, operand_2};
        shamt_big = (33'(operand_2) >= 33'(WIDTH));
        case (inst)
            4'd1: begin
                alu_sol   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                            (sum[WIDTH-1] != operand_1[WIDTH-1]);
            end
            4'd2: begin
                alu_sol   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                            (diff[WIDTH-1] != operand_1[WIDTH-1]);
            end
            4'd3:  alu_sol = operand_1 & operand_2;
            4'd4:  alu_sol = operand_1 | operand_2;
            4'd5:  alu_sol = operand_1 ^ operand_2;
            4'd6:  alu_sol = ~operand_1;
            4'd7:  alu_sol = shamt_big ? '0 : (operand_1 << operand_2);
            4'd8:  alu_sol = shamt_big ? '0 : (operand_1 >> operand_2);
            4'd9:  alu_sol = WIDTH'(operand_1 == operand_2);
            4'd10: alu_sol = '0;  // multiply goes through the MUL state
            4'd11: alu_sol = shamt_big ? {WIDTH{operand_1[WIDTH-1]}}
                                       : $unsigned($signed(operand_1) >>> operand_2);
            4'd12: alu_sol = WIDTH'(operand_1 < operand_2);
            default: alu_err = 1'b1;
        endcase
        alu_zero = !alu_err && (alu_sol == '0);
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    logic [2*WIDTH-1:0] acc_step;
    always_comb begin
        acc_step = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    end

    always_comb begin
        state_d = state_q;
        sol_d   = sol_q;
        flags_d = flags_q;
        acc_d   = acc_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (inst == 4'd10) begin
                        state_d = MUL;
                        acc_d   = '0;
                        a_sh_d  = {{WIDTH{1'b0}}, operand_1};
                        b_sh_d  = operand_2;
                        cnt_d   = '0;
                    end else begin
                        state_d = HOLD;
                        sol_d   = alu_sol;
                        flags_d = {alu_err, alu_ovf, alu_carry, alu_zero};
                    end
                end
            end
            MUL: begin
                acc_d  = acc_step;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                // Always WIDTH steps, even for zero operands, so latency is fixed.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = HOLD;
                    sol_d   = acc_step[WIDTH-1:0];
                    flags_d = {1'b0, 1'b0, |acc_step[2*WIDTH-1:WIDTH],
                               acc_step[WIDTH-1:0] == '0};
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sol_q   <= '0;
            flags_q <= '0;
            acc_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sol_q   <= sol_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign sol       = sol_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

endmodule
